eth_decap: RTL and testbench
============================

// Module: eth_decap
// PURPOSE
//  Receive side of the PCIe-TLP-over-UDP tunnel. Accepts 64-bit AXI-Stream Ethernet frames from the 10G MAC RX path.
//  Validates the 48-byte Eth+IPv4+UDP+tcap header (6 beats) and strips it.
//  Writes the remaining TLP payload beats into the 74-bit TLP FIFO in the same {tkeep,tdata,tlast,tuser} packing the TX encapsulator reads.
//  Frames that fail header checks are discarded whole and counted.
// PARAMETERS
//  local_mac  48'h00_11_22_33_44_55          accepted destination MAC (48'hFF..FF is also always accepted)
//  ip_daddr   {8'd192,8'd168,8'd11,8'd1}     accepted IPv4 destination address
//  udp_dport  16'h3776                       accepted UDP destination port
//  tcap_ver   3'b001                         required tcap header version
// PORTS
//  clk156          in   1   156.25 MHz clock; all logic on posedge
//  sys_rst_n       in   1   asynchronous, active-low reset
//  s_axis_tvalid   in   1   MAC RX beat valid
//  s_axis_tready   out  1   beat accepted when tvalid&&tready
//  s_axis_tdata    in   64  wire byte i of the beat in tdata[8i+7:8i]
//  s_axis_tkeep    in   8   byte enables
//  s_axis_tlast    in   1   last beat of frame
//  s_axis_tuser    in   1   MAC error flag; valid on tlast beat
//  wr_en           out  1   TLP FIFO write strobe
//  din             out  74  {tkeep[7:0],tdata[63:0],tlast,tuser}
//  full            in   1   TLP FIFO full
//  rx_pkt_cnt      out  32  frames forwarded; wraps
//  rx_drop_cnt     out  32  frames discarded; wraps
//  rx_last_seq     out  40  tcap ts/seq field of last forwarded frame
// BEHAVIOUR
//  Reset values (while sys_rst_n low):
//   - s_axis_tready=0, wr_en=0, din=0; all counters and rx_last_seq=0
//   - state=RX_HDR, beat count=0, hdr_ok=1
//  Reset mid-frame: the remaining beats of that frame after release are parsed as a new header.
//   - They normally fail the checks and are dropped.
//  States:
//   - RX_HDR:  tready=1. Count accepted beats 0..5 (3-bit) and AND the per-beat checks into hdr_ok. Checks:
//       beat0  bytes0-5 == local_mac or all-FF
//       beat1  bytes12-13 == 16'h0800; byte14 == 8'h45
//       beat2  byte23 == 8'd17 (UDP)
//       beat3  bytes30-31 == ip_daddr[31:16]
//       beat4  bytes32-33 == ip_daddr[15:0]; bytes36-37 == udp_dport
//       beat5  byte42[7:5] == tcap_ver; latch bytes43-47 (seq, big-endian) into a seq holding register
//       every header beat: tkeep == 8'hFF
//   - tlast on any header beat (incl. beat5, i.e. no payload):
//       - rx_drop_cnt++, stay RX_HDR, count=0
//   - Beat5 without tlast:
//       - hdr_ok -> RX_DATA
//       - else -> RX_DROP
//   - RX_DATA: tready = !full.
//       - Each accepted beat: wr_en=1, din={tkeep,tdata,tlast,tuser}, combinational and zero-latency.
//       - full=1: no beat accepted, no write.
//       - On accepted tlast: rx_pkt_cnt++, rx_last_seq <= held seq; -> RX_HDR, count=0, hdr_ok=1.
//       - tuser=1 frames are still forwarded; downstream discards them.
//   - RX_DROP: tready=1, no writes; on accepted tlast rx_drop_cnt++ -> RX_HDR.
//  Handshake and counters:
//   - tvalid=0 is a bubble in any state; no state or count change.
//   - wr_en is never asserted while full=1.
//   - Counters and rx_last_seq are registered; they update on the cycle after the tlast handshake.
// TESTING
//  1. Frame from encap with defaults (eth_dst=local_mac), 4 payload beats:
//     - 4 FIFO writes, din matching payload beats, last has tlast=1
//     - rx_pkt_cnt=1, rx_last_seq=seq in frame
//  2. Same frame, udp_dport=16'h1234:
//     - no wr_en, tready=1 throughout
//     - rx_drop_cnt=1, rx_pkt_cnt unchanged
//  3. 3-beat frame with tlast on beat2; then a valid frame back-to-back:
//     - drop_cnt=1; second frame forwarded intact, pkt_cnt=1
//  4. full=1 for 5 cycles mid-payload:
//     - tready=0 and wr_en=0 for those cycles
//     - no beat lost or duplicated after full=0
//  5. Broadcast dst 48'hFF..FF, tuser=1 on tlast:
//     - forwarded, last din[0]=1, pkt_cnt increments
//  6. sys_rst_n low for 2 cycles during payload beat 2:
//     - tready/wr_en=0 immediately; counters=0
//     - next valid frame forwarded correctly

Source files
------------

// File: rtl/eth_decap.sv
//==============================================================================
// Module      : eth_decap
// Description : RX side of the PCIe-TLP-over-UDP tunnel. Parses and validates
//               the 48-byte Eth+IPv4+UDP+tcap header (six 64-bit beats),
//               strips it, and writes the remaining TLP beats into the TLP
//               FIFO as {tkeep,tdata,tlast,tuser}. Failing frames are dropped
//               whole and counted.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module eth_decap #(
    parameter logic [47:0] LOCAL_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] IP_DADDR  = {8'd192, 8'd168, 8'd11, 8'd1},
    parameter logic [15:0] UDP_DPORT = 16'h3776,
    parameter logic [2:0]  TCAP_VER  = 3'b001
) (
    input  logic        clk156,
    input  logic        sys_rst_n,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        wr_en,
    output logic [73:0] din,
    input  logic        full,
    output logic [31:0] rx_pkt_cnt,
    output logic [31:0] rx_drop_cnt,
    output logic [39:0] rx_last_seq
);

    typedef enum logic [1:0] {
        RX_HDR  = 2'd0,
        RX_DATA = 2'd1,
        RX_DROP = 2'd2
    } state_t;

    localparam logic [2:0] C_LAST_HDR_BEAT = 3'd5;

    state_t      r_state;
    logic [2:0]  r_beat_cnt;
    logic        r_hdr_ok;
    logic [39:0] r_seq;
    logic        r_active;
    logic [31:0] r_pkt_cnt;
    logic [31:0] r_drop_cnt;
    logic [39:0] r_last_seq;

    logic [63:0] w_be;
    logic        w_beat_ok;
    logic        w_hs;
    logic        w_wr;

    // Network byte order view of the beat: wire byte 0 lands in bits [63:56]
    // so multi-byte header fields compare directly against big-endian values.
    for (genvar i = 0; i < 8; i++) begin : g_byte_swap
        assign w_be[8*(7-i) +: 8] = s_axis_tdata[8*i +: 8];
    end

    // Per-beat header field checks, selected by the header beat index
    always_comb begin
        w_beat_ok = (s_axis_tkeep == 8'hFF);
        case (r_beat_cnt)
            3'd0: if (!((w_be[63:16] == LOCAL_MAC) || (w_be[63:16] == 48'hFFFF_FFFF_FFFF)))
                      w_beat_ok = 1'b0;
            3'd1: if ((w_be[31:16] != 16'h0800) || (w_be[15:8] != 8'h45))
                      w_beat_ok = 1'b0;
            3'd2: if (w_be[7:0] != 8'd17)
                      w_beat_ok = 1'b0;
            3'd3: if (w_be[15:0] != IP_DADDR[31:16])
                      w_beat_ok = 1'b0;
            3'd4: if ((w_be[63:48] != IP_DADDR[15:0]) || (w_be[31:16] != UDP_DPORT))
                      w_beat_ok = 1'b0;
            3'd5: if (w_be[47:45] != TCAP_VER)
                      w_beat_ok = 1'b0;
            default: ;
        endcase
    end

    // Ready only once out of reset; payload phase is back-pressured by FIFO full.
    // The FIFO write is the accepted payload beat itself, with no added latency.
    assign s_axis_tready = r_active && ((r_state == RX_DATA) ? !full : 1'b1);
    assign w_hs          = s_axis_tvalid && s_axis_tready;
    assign w_wr          = w_hs && (r_state == RX_DATA);
    assign wr_en         = w_wr;
    assign din           = w_wr ? {s_axis_tkeep, s_axis_tdata, s_axis_tlast, s_axis_tuser} : 74'd0;

    assign rx_pkt_cnt  = r_pkt_cnt;
    assign rx_drop_cnt = r_drop_cnt;
    assign rx_last_seq = r_last_seq;

    // Frame parser: header accumulation, payload forwarding, drop handling
    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= RX_HDR;
            r_beat_cnt <= 3'd0;
            r_hdr_ok   <= 1'b1;
            r_seq      <= 40'd0;
            r_active   <= 1'b0;
            r_pkt_cnt  <= 32'd0;
            r_drop_cnt <= 32'd0;
            r_last_seq <= 40'd0;
        end else begin
            r_active <= 1'b1;
            if (w_hs) begin
                case (r_state)
                    RX_HDR: begin
                        if (s_axis_tlast) begin
                            // Frame ended inside the header (or with no payload)
                            r_drop_cnt <= r_drop_cnt + 32'd1;
                            r_beat_cnt <= 3'd0;
                            r_hdr_ok   <= 1'b1;
                        end else if (r_beat_cnt == C_LAST_HDR_BEAT) begin
                            r_seq      <= w_be[39:0];
                            r_state    <= (r_hdr_ok && w_beat_ok) ? RX_DATA : RX_DROP;
                            r_beat_cnt <= 3'd0;
                            r_hdr_ok   <= 1'b1;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 3'd1;
                            r_hdr_ok   <= r_hdr_ok && w_beat_ok;
                        end
                    end
                    RX_DATA: begin
                        if (s_axis_tlast) begin
                            r_pkt_cnt  <= r_pkt_cnt + 32'd1;
                            r_last_seq <= r_seq;
                            r_state    <= RX_HDR;
                        end
                    end
                    RX_DROP: begin
                        if (s_axis_tlast) begin
                            r_drop_cnt <= r_drop_cnt + 32'd1;
                            r_state    <= RX_HDR;
                        end
                    end
                    default: r_state <= RX_HDR;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_eth_decap.sv
//==============================================================================
// Module      : tb_eth_decap
// Description : Self-checking bench for eth_decap. Frames are built from
//               header fields, a byte-level model decides forward/drop and
//               queues expected FIFO words; a monitor checks every write.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_eth_decap;

    localparam logic [47:0] C_MAC   = 48'h00_11_22_33_44_55;
    localparam logic [31:0] C_IP    = {8'd192, 8'd168, 8'd11, 8'd1};
    localparam logic [15:0] C_DPORT = 16'h3776;

    logic        clk156 = 1'b0;
    logic        sys_rst_n;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic        wr_en;
    logic [73:0] din;
    logic        full;
    logic [31:0] rx_pkt_cnt;
    logic [31:0] rx_drop_cnt;
    logic [39:0] rx_last_seq;

    eth_decap dut (
        .clk156        (clk156),
        .sys_rst_n     (sys_rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .wr_en         (wr_en),
        .din           (din),
        .full          (full),
        .rx_pkt_cnt    (rx_pkt_cnt),
        .rx_drop_cnt   (rx_drop_cnt),
        .rx_last_seq   (rx_last_seq)
    );

    always #3.2 clk156 = ~clk156;

    int n_chk  = 0;
    int n_fail = 0;

    // Frame under construction
    logic [63:0] frm_data [0:15];
    logic [7:0]  frm_keep [0:15];
    logic        frm_last [0:15];
    logic        frm_user [0:15];
    int          frm_len;

    // Model state
    logic [73:0] exp_q [$];
    logic [31:0] exp_pkt  = 0;
    logic [31:0] exp_drop = 0;
    logic [39:0] exp_seq  = 0;
    logic [73:0] last_din = 0;
    int          wr_count = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Build a header from fields followed by npay payload beats
    task automatic build_frame(input logic [47:0] dst, input logic [15:0] dport,
                               input logic [39:0] seq, input int npay, input bit user_last);
        logic [7:0] hb [0:47];
        for (int i = 0; i < 48; i++) hb[i] = 8'(i);
        for (int i = 0; i < 6; i++) hb[i] = dst[8*(5-i) +: 8];
        hb[12] = 8'h08; hb[13] = 8'h00; hb[14] = 8'h45; hb[23] = 8'd17;
        for (int i = 0; i < 4; i++) hb[30+i] = C_IP[8*(3-i) +: 8];
        hb[36] = dport[15:8]; hb[37] = dport[7:0];
        hb[42] = 8'b001_00000;
        for (int i = 0; i < 5; i++) hb[43+i] = seq[8*(4-i) +: 8];
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 8; i++) frm_data[k][8*i +: 8] = hb[8*k+i];
            frm_keep[k] = 8'hFF; frm_last[k] = 1'b0; frm_user[k] = 1'b0;
        end
        for (int j = 0; j < npay; j++) begin
            frm_data[6+j] = {seq[23:0], 8'(j), 32'hDEAD_0000 + 32'(j)};
            frm_keep[6+j] = (j == npay-1) ? 8'h3F : 8'hFF;
            frm_last[6+j] = (j == npay-1);
            frm_user[6+j] = (j == npay-1) ? user_last : 1'b0;
        end
        frm_len = 6 + npay;
    endtask

    // Byte-level view of the frame beats [s, s+n) as the DUT will see them
    task automatic model_frame(input int s, input int n);
        logic [7:0]  b [0:47];
        bit          ok = 1'b1;
        bit          early = 1'b0;
        logic [47:0] mac;
        for (int k = 0; k < 6; k++) begin
            if (k < n) begin
                if (frm_last[s+k]) early = 1'b1;
                if (frm_keep[s+k] != 8'hFF) ok = 1'b0;
                for (int i = 0; i < 8; i++) b[8*k+i] = frm_data[s+k][8*i +: 8];
            end
        end
        if (n <= 6 || early) begin
            exp_drop++;
            return;
        end
        mac = {b[0], b[1], b[2], b[3], b[4], b[5]};
        if (!(mac == C_MAC || mac == 48'hFFFF_FFFF_FFFF)) ok = 1'b0;
        if ({b[12], b[13]} != 16'h0800 || b[14] != 8'h45) ok = 1'b0;
        if (b[23] != 8'd17) ok = 1'b0;
        if ({b[30], b[31], b[32], b[33]} != C_IP) ok = 1'b0;
        if ({b[36], b[37]} != C_DPORT) ok = 1'b0;
        if (b[42][7:5] != 3'b001) ok = 1'b0;
        if (ok) begin
            for (int k = 6; k < n; k++)
                exp_q.push_back({frm_keep[s+k], frm_data[s+k], frm_last[s+k], frm_user[s+k]});
            exp_pkt++;
            exp_seq = {b[43], b[44], b[45], b[46], b[47]};
        end else begin
            exp_drop++;
        end
    endtask

    task automatic drive_beat(input int idx);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = frm_data[idx];
        s_axis_tkeep  = frm_keep[idx];
        s_axis_tlast  = frm_last[idx];
        s_axis_tuser  = frm_user[idx];
    endtask

    // Present beats [s, s+n); leaves tvalid up so frames can follow back-to-back
    task automatic send_beats(input int s, input int n, input int stall_idx, input bit chk_rdy);
        for (int k = 0; k < n; k++) begin
            int w;
            @(posedge clk156); #1;
            drive_beat(s+k);
            if (s+k == stall_idx) begin
                full = 1'b1;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk156);
                    chk("stall_tready", 128'(s_axis_tready), 128'd0);
                    chk("stall_wr_en", 128'(wr_en), 128'd0);
                    @(posedge clk156); #1;
                end
                full = 1'b0;
            end
            w = 0;
            @(negedge clk156);
            while (!s_axis_tready && w < 50) begin
                @(negedge clk156);
                w++;
            end
            if (!s_axis_tready) chk("handshake_timeout", 128'(s_axis_tready), 128'd1);
            else if (chk_rdy) chk("drop_tready", 128'(s_axis_tready), 128'd1);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk156); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (n) @(posedge clk156);
        #1;
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_pkt_cnt"}, 128'(rx_pkt_cnt), 128'(exp_pkt));
        chk({tag, "_drop_cnt"}, 128'(rx_drop_cnt), 128'(exp_drop));
        chk({tag, "_last_seq"}, 128'(rx_last_seq), 128'(exp_seq));
    endtask

    // Monitor: every FIFO write must match the next expected word
    always @(negedge clk156) begin
        if (sys_rst_n === 1'b1) begin
            if (wr_en) begin
                wr_count++;
                last_din = din;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 128'(din), 128'd0);
                end else begin
                    chk("din", 128'(din), 128'(exp_q.pop_front()));
                end
                if (full) chk("write_while_full", 128'(full), 128'd0);
            end
        end
    end

    initial begin
        int wr0;
        sys_rst_n = 1'b0;
        full = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
        s_axis_tlast = 1'b0;  s_axis_tuser = 1'b0;
        repeat (3) @(posedge clk156);
        @(negedge clk156);
        chk("rst_tready", 128'(s_axis_tready), 128'd0);
        chk("rst_wr_en", 128'(wr_en), 128'd0);
        chk("rst_din", 128'(din), 128'd0);
        chk_counters("rst");
        sys_rst_n = 1'b1;

        // 1: unicast frame with 4 payload beats
        wr0 = wr_count;
        build_frame(C_MAC, C_DPORT, 40'h0A_0B0C_0D0E, 4, 1'b0);
        model_frame(0, frm_len);
        send_beats(0, frm_len, -1, 1'b0);
        idle(3);
        chk_counters("t1");
        chk("t1_pkt_literal", 128'(rx_pkt_cnt), 128'd1);
        chk("t1_seq_literal", 128'(rx_last_seq), 128'h0A0B0C0D0E);
        chk("t1_writes", 128'(wr_count - wr0), 128'd4);
        chk("t1_last_din", 128'(last_din), 128'({8'h3F, 64'h0C0D0E03_DEAD0003, 1'b1, 1'b0}));

        // 2: wrong UDP port is dropped whole, tready stays high
        build_frame(C_MAC, 16'h1234, 40'h11_2233_4455, 4, 1'b0);
        model_frame(0, frm_len);
        send_beats(0, frm_len, -1, 1'b1);
        idle(3);
        chk_counters("t2");
        chk("t2_drop_literal", 128'(rx_drop_cnt), 128'd1);

        // 3: truncated 3-beat frame, then a valid frame back-to-back
        build_frame(C_MAC, C_DPORT, 40'h55_6677_8899, 4, 1'b0);
        frm_last[2] = 1'b1; frm_len = 3;
        model_frame(0, frm_len);
        send_beats(0, frm_len, -1, 1'b0);
        build_frame(C_MAC, C_DPORT, 40'h21_2223_2425, 3, 1'b0);
        model_frame(0, frm_len);
        send_beats(0, frm_len, -1, 1'b0);
        idle(3);
        chk_counters("t3");
        chk("t3_drop_literal", 128'(rx_drop_cnt), 128'd2);

        // 4: FIFO full for 5 cycles on payload beat 2
        build_frame(C_MAC, C_DPORT, 40'h31_3233_3435, 5, 1'b0);
        model_frame(0, frm_len);
        send_beats(0, frm_len, 8, 1'b0);
        idle(3);
        chk_counters("t4");

        // 5: broadcast destination, tuser on tlast still forwarded
        build_frame(48'hFFFF_FFFF_FFFF, C_DPORT, 40'h41_4243_4445, 2, 1'b1);
        model_frame(0, frm_len);
        send_beats(0, frm_len, -1, 1'b0);
        idle(3);
        chk_counters("t5");
        chk("t5_pkt_literal", 128'(rx_pkt_cnt), 128'd4);
        chk("t5_tuser_bit", 128'(last_din[1:0]), 128'd3);

        // 6: reset asserted while payload beat 2 is presented
        build_frame(C_MAC, C_DPORT, 40'h51_5253_5455, 4, 1'b0);
        exp_q.push_back({frm_keep[6], frm_data[6], frm_last[6], frm_user[6]});
        exp_q.push_back({frm_keep[7], frm_data[7], frm_last[7], frm_user[7]});
        send_beats(0, 8, -1, 1'b0);
        @(posedge clk156); #1;
        drive_beat(8);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("t6_rst_tready", 128'(s_axis_tready), 128'd0);
        chk("t6_rst_wr_en", 128'(wr_en), 128'd0);
        exp_q.delete();
        exp_pkt = 0; exp_drop = 0; exp_seq = 0;
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk156);
        #1;
        chk_counters("t6_rst");
        @(negedge clk156);
        sys_rst_n = 1'b1;
        model_frame(8, 2);
        send_beats(8, 2, -1, 1'b0);
        idle(2);
        build_frame(C_MAC, C_DPORT, 40'h61_6263_6465, 3, 1'b0);
        model_frame(0, frm_len);
        send_beats(0, frm_len, -1, 1'b0);
        idle(3);
        chk_counters("t6");
        chk("t6_pkt_literal", 128'(rx_pkt_cnt), 128'd1);
        chk("t6_drop_literal", 128'(rx_drop_cnt), 128'd1);
        chk("exp_queue_drained", 128'(exp_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
